link_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-phase req/ack link slave among N link masters. It sits between the masters and the slave inside the link top level. It grants one master at a time, forwards that master's req and data to the slave, and returns the slave's ack to the granted master only. All outputs are registered, and a granted transfer always runs through the full 4-phase handshake before the arbiter re-arbitrates.

---
 rtl/link_arbiter.sv | 151 +++++++++++++++
 tb/tb_link_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_arbiter.sv
// -----------------------------------------------------------------------------
// link_arbiter
//
// Round-robin arbiter sharing one 4-phase req/ack link slave among N link
// masters. One master is granted at a time. The granted master's data is
// captured once and forwarded to the slave together with s_req_o. The slave's
// ack is returned to the granted master only. Every granted transfer runs the
// complete 4-phase handshake before the arbiter picks the next winner.
//
// Handshake (4-phase, level based, both sides):
//   req rises -> ack rises -> req falls -> ack falls.
//   On the master side m_req_i[w] / m_ack_o[w] follow this order.
//   On the slave side s_req_o / s_ack_i follow this order.
//   s_data_o is held from the req rise until after the ack fall.
//
// Optional feature macro: LINK_ARB_STATS_EN. When it is defined, the port
// xfer_cnt_o provides a 16-bit wrapping count of completed transfers per
// master.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active low
//   m_req_i    : per-master request (bit i = master i)
//   m_data_i   : per-master data, master i at [i*DW +: DW]
//   m_ack_o    : per-master acknowledge (at most one bit set)
//   s_req_o    : request to the slave
//   s_data_o   : data to the slave
//   s_ack_i    : acknowledge from the slave
//   grant_o    : one-hot current owner, zero in IDLE
//   busy_o     : high in every state except IDLE
//   state_o    : FSM state (0 IDLE, 1 REQ, 2 HOLD, 3 REL), for debug
//   xfer_cnt_o : completed transfers per master, 16 bits each
//                (only with LINK_ARB_STATS_EN)
// -----------------------------------------------------------------------------
module link_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    m_req_i,
  input  logic [N*DW-1:0] m_data_i,
  output logic [N-1:0]    m_ack_o,
  output logic            s_req_o,
  output logic [DW-1:0]   s_data_o,
  input  logic            s_ack_i,
  output logic [N-1:0]    grant_o,
  output logic            busy_o,
  output logic [1:0]      state_o
`ifdef LINK_ARB_STATS_EN
  ,
  output logic [N*16-1:0] xfer_cnt_o
`endif
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t        state_q;
  logic [LW-1:0] last_q;   // most recently served master
  logic [LW-1:0] win_q;    // owner of the transfer in flight
  logic [LW-1:0] win_d;    // round-robin pick among current requests
  logic          any_req;

  // Round-robin scan: start one past the last winner and wrap upward. The
  // first requesting master found wins.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    win_d   = '0;
    any_req = |m_req_i;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && m_req_i[idx]) begin
        win_d = LW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_req_o  <= 1'b0;
      s_data_o <= '0;
      m_ack_o  <= '0;
      grant_o  <= '0;
      win_q    <= '0;
      // Reset to N-1 so that the scan starts at master 0.
      last_q   <= LW'(N - 1);
`ifdef LINK_ARB_STATS_EN
      xfer_cnt_o <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_o  <= N'(1) << win_d;
            // Data is captured only here. Later changes on m_data_i are ignored.
            s_data_o <= m_data_i[int'(win_d)*DW +: DW];
            s_req_o  <= 1'b1;
            win_q    <= win_d;
            state_q  <= REQ;
          end
        end
        REQ: begin
          // A master dropping its request here is a protocol violation. It is
          // ignored, so the slave handshake still completes.
          if (s_ack_i) begin
            m_ack_o[win_q] <= 1'b1;
            state_q        <= HOLD;
          end
        end
        HOLD: begin
          // An early fall of s_ack_i is ignored. Only the master's release
          // moves the FSM on.
          if (!m_req_i[win_q]) begin
            s_req_o <= 1'b0;
            state_q <= REL;
          end
        end
        REL: begin
          if (!s_ack_i) begin
            m_ack_o <= '0;
            grant_o <= '0;
            last_q  <= win_q;
`ifdef LINK_ARB_STATS_EN
            xfer_cnt_o[int'(win_q)*16 +: 16] <= xfer_cnt_o[int'(win_q)*16 +: 16] + 16'd1;
`endif
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decoded directly from the state register. The asynchronous reset
  // therefore clears busy_o at once, together with the other outputs.
  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_link_arbiter
//
// Directed bench for link_arbiter with N=4 and DW=8.
// - A vector table covers the single requester, contention after reset,
//   REQ-phase request drop and HOLD-phase early ack drop.
// - Hand-written sequences cover fairness/wrap-around, data capture, reset
//   mid-transfer and the optional transfer counters.
// Outputs are sampled 1 time unit after the rising edge. Inputs are driven at
// the same point.
// -----------------------------------------------------------------------------
module tb_link_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic            clk;
  logic            rst_n;
  logic [N-1:0]    m_req;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]    m_ack;
  logic            s_req;
  logic [DW-1:0]   s_data;
  logic            s_ack;
  logic [N-1:0]    grant;
  logic            busy;
  logic [1:0]      state;
`ifdef LINK_ARB_STATS_EN
  logic [N*16-1:0] xfer_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  link_arbiter #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req_i  (m_req),
    .m_data_i (m_data),
    .m_ack_o  (m_ack),
    .s_req_o  (s_req),
    .s_data_o (s_data),
    .s_ack_i  (s_ack),
    .grant_o  (grant),
    .busy_o   (busy),
    .state_o  (state)
`ifdef LINK_ARB_STATS_EN
    ,
    .xfer_cnt_o (xfer_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fail;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    m_req  = '0;
    m_data = '0;
    s_ack  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Waits a bounded number of cycles for a DUT condition.
  task automatic wait_until(input int sel, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      case (sel)
        0:       hit = (grant != '0);
        1:       hit = (m_ack != '0);
        2:       hit = !s_req;
        3:       hit = (grant == '0);
        default: hit = 1'b1;
      endcase
      if (!hit) step();
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after 30 cycles", name);
    end
  endtask

  // Runs one complete transfer for whoever gets the grant. It acts as the
  // slave and as the granted master. When rereq is set, that master asks
  // again once the arbiter has returned to IDLE.
  task automatic serve(input bit rereq, output logic [N-1:0] g);
    int idx;
    idx = 0;
    wait_until(0, "grant_wait");
    g = grant;
    check("grant_onehot", 64'($onehot0(grant)), 64'd1);
    s_ack = 1'b1;
    wait_until(1, "ack_wait");
    check("m_ack_to_owner", m_ack, g);
    for (int i = 0; i < N; i++) if (g[i]) idx = i;
    m_req[idx] = 1'b0;
    wait_until(2, "s_req_fall");
    s_ack = 1'b0;
    wait_until(3, "grant_clear");
    if (rereq) m_req[idx] = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit              rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic            ack;
    logic [17:0]     exp;   // {s_req, s_data, grant, m_ack, busy}
  } vec_t;

  localparam int NV = 25;
  vec_t vt[NV];

  function automatic vec_t mk(bit rst, logic [3:0] req, logic [31:0] data, logic ack,
                              logic sr, logic [7:0] sd, logic [3:0] gr, logic [3:0] ma, logic bz);
    vec_t v;
    v.rst  = rst;
    v.req  = req;
    v.data = data;
    v.ack  = ack;
    v.exp  = {sr, sd, gr, ma, bz};
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N-1:0] g;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    m_req    = '0;
    m_data   = '0;
    s_ack    = 1'b0;

    // Single requester: master 2, data A5, slave acks after 3 cycles.
    vt[0]  = mk(1, 4'b0100, 32'h00A5_0000, 0, 1, 8'hA5, 4'b0100, 4'b0000, 1);
    vt[1]  = mk(0, 4'b0100, 32'h00A5_0000, 0, 1, 8'hA5, 4'b0100, 4'b0000, 1);
    vt[2]  = mk(0, 4'b0100, 32'h00A5_0000, 0, 1, 8'hA5, 4'b0100, 4'b0000, 1);
    vt[3]  = mk(0, 4'b0100, 32'h00A5_0000, 1, 1, 8'hA5, 4'b0100, 4'b0100, 1);
    vt[4]  = mk(0, 4'b0000, 32'h00A5_0000, 1, 0, 8'hA5, 4'b0100, 4'b0100, 1);
    vt[5]  = mk(0, 4'b0000, 32'h00A5_0000, 0, 0, 8'hA5, 4'b0000, 4'b0000, 0);
    vt[6]  = mk(0, 4'b0000, 32'h00A5_0000, 0, 0, 8'hA5, 4'b0000, 4'b0000, 0);
    // Contention after reset: masters 0 and 1 together; 0 first, then 1.
    vt[7]  = mk(1, 4'b0011, 32'h0000_2110, 0, 1, 8'h10, 4'b0001, 4'b0000, 1);
    vt[8]  = mk(0, 4'b0011, 32'h0000_2110, 1, 1, 8'h10, 4'b0001, 4'b0001, 1);
    vt[9]  = mk(0, 4'b0010, 32'h0000_2110, 1, 0, 8'h10, 4'b0001, 4'b0001, 1);
    vt[10] = mk(0, 4'b0010, 32'h0000_2110, 0, 0, 8'h10, 4'b0000, 4'b0000, 0);
    vt[11] = mk(0, 4'b0010, 32'h0000_2110, 0, 1, 8'h21, 4'b0010, 4'b0000, 1);
    vt[12] = mk(0, 4'b0010, 32'h0000_2110, 1, 1, 8'h21, 4'b0010, 4'b0010, 1);
    vt[13] = mk(0, 4'b0000, 32'h0000_2110, 1, 0, 8'h21, 4'b0010, 4'b0010, 1);
    vt[14] = mk(0, 4'b0000, 32'h0000_2110, 0, 0, 8'h21, 4'b0000, 4'b0000, 0);
    // Master 3 drops its request while in REQ: ignored, waits for s_ack.
    vt[15] = mk(0, 4'b1000, 32'h3300_0000, 0, 1, 8'h33, 4'b1000, 4'b0000, 1);
    vt[16] = mk(0, 4'b0000, 32'h3300_0000, 0, 1, 8'h33, 4'b1000, 4'b0000, 1);
    vt[17] = mk(0, 4'b0000, 32'h3300_0000, 1, 1, 8'h33, 4'b1000, 4'b1000, 1);
    vt[18] = mk(0, 4'b0000, 32'h3300_0000, 0, 0, 8'h33, 4'b1000, 4'b1000, 1);
    vt[19] = mk(0, 4'b0000, 32'h3300_0000, 0, 0, 8'h33, 4'b0000, 4'b0000, 0);
    // After master 3, the scan wraps to master 0. An early s_ack drop in HOLD
    // is ignored.
    vt[20] = mk(0, 4'b0001, 32'h0000_0044, 0, 1, 8'h44, 4'b0001, 4'b0000, 1);
    vt[21] = mk(0, 4'b0001, 32'h0000_0044, 1, 1, 8'h44, 4'b0001, 4'b0001, 1);
    vt[22] = mk(0, 4'b0001, 32'h0000_0044, 0, 1, 8'h44, 4'b0001, 4'b0001, 1);
    vt[23] = mk(0, 4'b0000, 32'h0000_0044, 0, 0, 8'h44, 4'b0001, 4'b0001, 1);
    vt[24] = mk(0, 4'b0000, 32'h0000_0044, 0, 0, 8'h44, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].rst) begin
        do_reset();
        check("reset_state", {s_req, s_data, grant, m_ack, busy}, 18'h0);
      end
      m_req  = vt[i].req;
      m_data = vt[i].data;
      s_ack  = vt[i].ack;
      step();
      check($sformatf("vec%0d", i), {s_req, s_data, grant, m_ack, busy}, vt[i].exp);
    end

    // Fairness: all masters request continuously. The grant order must be
    // 0,1,2,3,0,1,2,3.
    do_reset();
    m_req = 4'b1111;
    m_data = 32'h4433_2211;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) exp_q.push_back(N'(1) << k);
    for (int t = 0; t < 2 * N; t++) begin
      serve(1'b1, g);
      check($sformatf("fair_grant%0d", t), g, exp_q.pop_front());
    end
    m_req = '0;
    step();

    // Data capture: master 3 changes its data while in REQ.
    do_reset();
    m_data = 32'h1100_0000;
    m_req  = 4'b1000;
    step();
    check("cap_grant", grant, 4'b1000);
    check("cap_idle_req", s_data, 8'h11);
    m_data = 32'h2200_0000;
    step();
    check("cap_req", s_data, 8'h11);
    s_ack = 1'b1;
    step();
    check("cap_hold", s_data, 8'h11);
    m_req = '0;
    step();
    check("cap_rel", s_data, 8'h11);
    s_ack = 1'b0;
    step();
    check("cap_done", {grant, s_data}, {4'b0000, 8'h11});

    // Asynchronous reset while in HOLD.
    do_reset();
    m_data = 32'h0000_5500;
    m_req  = 4'b0010;
    step();
    s_ack = 1'b1;
    step();
    check("pre_rst_hold", {s_req, grant, m_ack, busy}, {1'b1, 4'b0010, 4'b0010, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {s_req, grant, m_ack, busy}, 10'h0);
    m_req = '0;
    s_ack = 1'b0;
    #5;
    rst_n = 1'b1;
    step();
    check("post_rst_idle", {s_req, grant, m_ack, busy}, 10'h0);

`ifdef LINK_ARB_STATS_EN
    // Counters: three transfers for master 1, one for master 3.
    do_reset();
    check("cnt_reset", xfer_cnt, 64'h0);
    for (int t = 0; t < 3; t++) begin
      m_req = 4'b0010;
      serve(1'b0, g);
      check("cnt_m1_grant", g, 4'b0010);
    end
    m_req = 4'b1000;
    serve(1'b0, g);
    check("cnt_m3_grant", g, 4'b1000);
    step();
    check("xfer_cnt", xfer_cnt, {16'd1, 16'd0, 16'd3, 16'd0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
